mem_seq: RTL and testbench

- Sequential memory sequencer between the CPU's IF/MEM stages and the byte-wide, single-port RAM.
- Arbitrates one transaction at a time between instruction fetch and data load/store. MEM has fixed priority; there is no preemption.
- Serialises each 1/2/4-byte access into per-byte RAM cycles, assembles read data little-endian, and returns a one-cycle done pulse to the granted requester.

---
 rtl/mem_seq_if.sv | 34 +++
 rtl/mem_seq.sv | 185 ++++++++++++++++++
 tb/tb_mem_seq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_if.sv
// Bundle of the CPU fetch port, CPU data port and byte-wide RAM port seen by mem_seq.
// The sequencer takes the slave view; the CPU/RAM environment takes the master view.
interface mem_seq_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_inst;

    logic [1:0]        mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    logic [1:0]        grant;

    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport slave (
        input  if_req, if_addr, mem_req, mem_addr, mem_len, mem_wdata, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, grant, ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_req, if_addr, mem_req, mem_addr, mem_len, mem_wdata, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, grant, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_seq.sv
// Serialises IF fetches and MEM loads/stores into per-byte accesses on a single-port
// byte RAM; MEM has fixed priority, one transaction at a time, all outputs registered.
module mem_seq #(
    parameter int ADDR_W = 32
) (
    input  logic     clk,
    input  logic     rst,
    mem_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic              ownMem_q, ownMem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] ramA_q, ramA_d;
    logic [7:0]        ramDout_q, ramDout_d;
    logic              ramWr_q, ramWr_d;
    logic              ifDone_q, ifDone_d;
    logic              memDone_q, memDone_d;
    logic [31:0]       ifInst_q, ifInst_d;
    logic [31:0]       memRdata_q, memRdata_d;

    logic [2:0]        memLenN;
    logic [2:0]        lenPlusOne;
    logic [1:0]        capIdx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            ownMem_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            grant_q    <= 2'b00;
            ramA_q     <= '0;
            ramDout_q  <= '0;
            ramWr_q    <= 1'b0;
            ifDone_q   <= 1'b0;
            memDone_q  <= 1'b0;
            ifInst_q   <= '0;
            memRdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ownMem_q   <= ownMem_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            grant_q    <= grant_d;
            ramA_q     <= ramA_d;
            ramDout_q  <= ramDout_d;
            ramWr_q    <= ramWr_d;
            ifDone_q   <= ifDone_d;
            memDone_q  <= memDone_d;
            ifInst_q   <= ifInst_d;
            memRdata_q <= memRdata_d;
        end
    end

    // cnt_q counts edges since acceptance; in RD the byte issued k edges ago returns two edges later.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ownMem_d   = ownMem_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        grant_d    = grant_q;
        ramA_d     = ramA_q;
        ramDout_d  = ramDout_q;
        ramWr_d    = ramWr_q;
        ifDone_d   = 1'b0;
        memDone_d  = 1'b0;
        ifInst_d   = ifInst_q;
        memRdata_d = memRdata_q;

        memLenN    = (bus.mem_len == 2'b00) ? 3'd1 :
                     (bus.mem_len == 2'b01) ? 3'd2 : 3'd4;
        lenPlusOne = len_q + 3'd1;
        capIdx     = 2'(cnt_q - 3'd2);

        case (state_q)
            IDLE: begin
                if (bus.mem_req == 2'b01 || bus.mem_req == 2'b10) begin
                    ownMem_d = 1'b1;
                    addr_d   = bus.mem_addr;
                    wdata_d  = bus.mem_wdata;
                    len_d    = memLenN;
                    grant_d  = 2'b10;
                    cnt_d    = 3'd1;
                    ramA_d   = bus.mem_addr;
                    if (bus.mem_req == 2'b10) begin
                        state_d   = WR;
                        ramDout_d = bus.mem_wdata[7:0];
                        ramWr_d   = 1'b1;
                    end else begin
                        state_d = RD;
                        ramWr_d = 1'b0;
                        // Bytes beyond the load length read back as zero.
                        case (memLenN)
                            3'd1:    memRdata_d = {24'h0, memRdata_q[7:0]};
                            3'd2:    memRdata_d = {16'h0, memRdata_q[15:0]};
                            default: memRdata_d = memRdata_q;
                        endcase
                    end
                end else if (bus.if_req) begin
                    ownMem_d = 1'b0;
                    addr_d   = bus.if_addr;
                    len_d    = 3'd4;
                    grant_d  = 2'b01;
                    cnt_d    = 3'd1;
                    ramA_d   = bus.if_addr;
                    ramWr_d  = 1'b0;
                    state_d  = RD;
                end
            end

            RD: begin
                if (cnt_q < len_q) begin
                    ramA_d = addr_q + ADDR_W'(cnt_q);
                end
                if (cnt_q >= 3'd2) begin
                    if (ownMem_q) begin
                        memRdata_d[{capIdx, 3'b000} +: 8] = bus.ram_din;
                    end else begin
                        ifInst_d[{capIdx, 3'b000} +: 8] = bus.ram_din;
                    end
                end
                if (cnt_q == lenPlusOne) begin
                    state_d = DONE;
                    if (ownMem_q) begin
                        memDone_d = 1'b1;
                    end else begin
                        ifDone_d = 1'b1;
                    end
                end
                cnt_d = cnt_q + 3'd1;
            end

            WR: begin
                if (cnt_q < len_q) begin
                    ramA_d    = addr_q + ADDR_W'(cnt_q);
                    ramDout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    ramWr_d   = 1'b1;
                end else begin
                    ramWr_d   = 1'b0;
                    state_d   = DONE;
                    memDone_d = 1'b1;
                end
                cnt_d = cnt_q + 3'd1;
            end

            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
                cnt_d   = 3'd0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.if_done   = ifDone_q;
    assign bus.if_inst   = ifInst_q;
    assign bus.mem_done  = memDone_q;
    assign bus.mem_rdata = memRdata_q;
    assign bus.grant     = grant_q;
    assign bus.ram_a     = ramA_q;
    assign bus.ram_dout  = ramDout_q;
    assign bus.ram_wr    = ramWr_q;

endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq: a byte-addressed reference memory predicts every
// done response, and a negedge monitor pops and compares whenever a done pulse appears.
module tb_mem_seq;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_seq_if #(.ADDR_W(ADDR_W)) bus ();

    mem_seq #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rdata;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        ifQ[$];
    exp_t        memQ[$];
    exp_t        monE;
    logic [31:0] modelInst;
    logic [31:0] modelRdata;
    logic [7:0]  refMem[logic [31:0]];
    logic [7:0]  ramMem[logic [31:0]];

    // Power-up contents shared by the RAM and the reference (a fixed instruction at 0x100).
    function automatic logic [7:0] initByte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'hA0;
            32'h103: return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] refRead(input logic [31:0] a);
        if (refMem.exists(a)) return refMem[a];
        return initByte(a);
    endfunction

    function automatic int lenBytes(input logic [1:0] len);
        if (len == 2'b00) return 1;
        if (len == 2'b01) return 2;
        return 4;
    endfunction

    // Synchronous byte RAM: samples address/write at the edge, read data appears after it.
    always @(posedge clk) begin
        logic [7:0] rd;
        rd = ramMem.exists(bus.ram_a) ? ramMem[bus.ram_a] : initByte(bus.ram_a);
        if (bus.ram_wr === 1'b1) ramMem[bus.ram_a] = bus.ram_dout;
        bus.ram_din <= rd;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.if_done === 1'b1) begin
            if (ifQ.size() == 0) begin
                checkOutput("if_done unexpected", {31'b0, bus.if_done}, 32'd0);
            end else begin
                monE = ifQ.pop_front();
                checkOutput("if_inst", bus.if_inst, monE.inst);
                checkOutput("mem_rdata kept during IF", bus.mem_rdata, monE.rdata);
            end
        end
        if (bus.mem_done === 1'b1) begin
            if (memQ.size() == 0) begin
                checkOutput("mem_done unexpected", {31'b0, bus.mem_done}, 32'd0);
            end else begin
                monE = memQ.pop_front();
                checkOutput("mem_rdata", bus.mem_rdata, monE.rdata);
                checkOutput("if_inst kept during MEM", bus.if_inst, monE.inst);
            end
        end
    end

    // Reference: stores update memory, loads/fetches assemble little-endian with zero fill.
    task automatic issueModel(input int kind, input logic [31:0] addr, input logic [1:0] len,
                              input logic [31:0] wdata);
        int          n;
        logic [31:0] val;
        logic [31:0] a;
        exp_t        e;
        n   = (kind == 0) ? 4 : lenBytes(len);
        val = 32'h0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            if (kind == 2) refMem[a] = wdata[8*k +: 8];
            else           val[8*k +: 8] = refRead(a);
        end
        if (kind == 0)      modelInst  = val;
        else if (kind == 1) modelRdata = val;
        e.inst  = modelInst;
        e.rdata = modelRdata;
        if (kind == 0) ifQ.push_back(e);
        else           memQ.push_back(e);
    endtask

    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [1:0] len,
                                 input logic [31:0] wdata);
        case (kind)
            0: begin
                bus.if_req  = 1'b1;
                bus.if_addr = addr;
            end
            1: begin
                bus.mem_req  = 2'b01;
                bus.mem_addr = addr;
                bus.mem_len  = len;
            end
            default: begin
                bus.mem_req   = 2'b10;
                bus.mem_addr  = addr;
                bus.mem_len   = len;
                bus.mem_wdata = wdata;
            end
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic runTxn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] wdata);
        int n;
        int lat;
        int cyc;
        bit done;
        n   = (kind == 0) ? 4 : lenBytes(len);
        lat = (kind == 2) ? n : n + 1;
        issueModel(kind, addr, len, wdata);
        applyStimulus(kind, addr, len, wdata);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) checkOutput("grant", {30'b0, bus.grant}, (kind == 0) ? 32'd1 : 32'd2);
            if (cyc <= n) begin
                checkOutput("ram_a", bus.ram_a, addr + 32'(cyc - 1));
                if (kind == 2) begin
                    checkOutput("ram_wr store", {31'b0, bus.ram_wr}, 32'd1);
                    checkOutput("ram_dout", {24'b0, bus.ram_dout}, {24'b0, wdata[8*(cyc-1) +: 8]});
                end else begin
                    checkOutput("ram_wr read", {31'b0, bus.ram_wr}, 32'd0);
                end
            end
            done = (kind == 0) ? (bus.if_done === 1'b1) : (bus.mem_done === 1'b1);
        end
        checkOutput("done latency", 32'(cyc), 32'(lat + 1));
        if (kind == 2) checkOutput("ram_wr after store", {31'b0, bus.ram_wr}, 32'd0);
        bus.if_req  = 1'b0;
        bus.mem_req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        checkOutput("grant idle after DONE", {30'b0, bus.grant}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cyc;
        int          kind;
        logic [31:0] addr;
        logic [1:0]  len;

        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 2'b00;
        bus.mem_addr  = '0;
        bus.mem_len   = 2'b00;
        bus.mem_wdata = '0;
        modelInst     = '0;
        modelRdata    = '0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset grant",     {30'b0, bus.grant},    32'd0);
        checkOutput("reset ram_a",     bus.ram_a,             32'd0);
        checkOutput("reset ram_dout",  {24'b0, bus.ram_dout}, 32'd0);
        checkOutput("reset ram_wr",    {31'b0, bus.ram_wr},   32'd0);
        checkOutput("reset if_done",   {31'b0, bus.if_done},  32'd0);
        checkOutput("reset mem_done",  {31'b0, bus.mem_done}, 32'd0);
        checkOutput("reset if_inst",   bus.if_inst,           32'd0);
        checkOutput("reset mem_rdata", bus.mem_rdata,         32'd0);
        rst = 1'b0;

        $display("[TB] directed fetch, store, loads");
        runTxn(0, 32'h100, 2'b00, 32'h0);
        checkOutput("fetch vector", bus.if_inst, 32'h00A00513);
        runTxn(2, 32'h2000, 2'b10, 32'hDEADBEEF);
        runTxn(1, 32'h2002, 2'b01, 32'h0);
        checkOutput("load half vector", bus.mem_rdata, 32'h0000DEAD);
        runTxn(1, 32'h2000, 2'b00, 32'h0);
        checkOutput("load byte vector", bus.mem_rdata, 32'h000000EF);

        $display("[TB] simultaneous IF and MEM requests");
        issueModel(1, 32'h2000, 2'b10, 32'h0);
        issueModel(0, 32'h100, 2'b00, 32'h0);
        bus.mem_req  = 2'b01;
        bus.mem_addr = 32'h2000;
        bus.mem_len  = 2'b10;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h100;
        @(posedge clk);
        @(negedge clk);
        checkOutput("arb grant MEM first", {30'b0, bus.grant}, 32'd2);
        cyc = 1;
        while (bus.mem_done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checkOutput("arb MEM latency", 32'(cyc), 32'd6);
        bus.mem_req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        checkOutput("arb grant idle after DONE", {30'b0, bus.grant}, 32'd0);
        checkOutput("arb if_done not early", {31'b0, bus.if_done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("arb IF granted next", {30'b0, bus.grant}, 32'd1);
        cyc = 1;
        while (bus.if_done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checkOutput("arb IF latency", 32'(cyc), 32'd6);
        bus.if_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("arb grant idle at end", {30'b0, bus.grant}, 32'd0);

        $display("[TB] reset during word store");
        refMem[32'h2100] = 8'h44;
        refMem[32'h2101] = 8'h33;
        applyStimulus(2, 32'h2100, 2'b10, 32'h11223344);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst ram_wr",    {31'b0, bus.ram_wr},   32'd0);
        checkOutput("rst grant",     {30'b0, bus.grant},    32'd0);
        checkOutput("rst mem_done",  {31'b0, bus.mem_done}, 32'd0);
        checkOutput("rst mem_rdata", bus.mem_rdata,         32'd0);
        checkOutput("rst if_inst",   bus.if_inst,           32'd0);
        modelInst   = '0;
        modelRdata  = '0;
        rst         = 1'b0;
        bus.mem_req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        runTxn(1, 32'h2100, 2'b10, 32'h0);

        $display("[TB] address wrap and ignored mem_req=11");
        runTxn(0, 32'hFFFFFFFE, 2'b00, 32'h0);
        bus.mem_req = 2'b11;
        runTxn(0, 32'h300, 2'b00, 32'h0);

        $display("[TB] random transactions");
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + $urandom_range(0, 31);
            len  = 2'($urandom_range(0, 3));
            runTxn(kind, addr, len, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                @(negedge clk);
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("ifQ drained",  32'(ifQ.size()),  32'd0);
        checkOutput("memQ drained", 32'(memQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
